// File: rtl/edsac_ctrl_pkg.sv
// Shared types and constants for the control-section serial counters.
// Holds the per-word command encoding and its priority decode.
package edsac_ctrl_pkg;

  localparam int unsigned WORD_LEN_DEFAULT = 18;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_INC,
    CMD_SKIP,
    CMD_LOAD,
    CMD_CLEAR
  } cmd_e;

  // Priority: clear > load > skip > inc > idle.
  function automatic cmd_e decode_cmd(input logic inc, input logic skip, input logic load,
                                      input logic clear);
    cmd_e result;
    result = CMD_IDLE;
    if (clear) begin
      result = CMD_CLEAR;
    end else if (load) begin
      result = CMD_LOAD;
    end else if (skip) begin
      result = CMD_SKIP;
    end else if (inc) begin
      result = CMD_INC;
    end
    return result;
  endfunction

endpackage

// File: rtl/delay.sv
// Fixed-length serial delay line of INTERVAL pulse intervals.
// Used both as the recirculating store and as the output timing pipe.
module delay #(
  parameter int unsigned INTERVAL = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [INTERVAL-1:0] line_q;

  if (INTERVAL == 1) begin : g_single
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        line_q <= '0;
      end else begin
        line_q <= d_i;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        line_q <= '0;
      end else begin
        line_q <= {line_q[INTERVAL-2:0], d_i};
      end
    end
  end

  assign q_o = line_q[INTERVAL-1];

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial full adder with a carry flip-flop.
// carry_clr_i masks the stored carry for the current bit, isolating words.
module serial_full_adder (
  input  logic clk_i,
  input  logic reset_i,
  input  logic carry_clr_i,
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  logic carry_q;
  logic carry_in;

  assign carry_in = carry_clr_i ? 1'b0 : carry_q;
  assign sum_o    = a_i ^ b_i ^ carry_in;
  assign carry_o  = (a_i & b_i) | (a_i & carry_in) | (b_i & carry_in);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_o;
    end
  end

endmodule

// File: rtl/serial_count_line.sv
// Recirculating serial delay-line counter, LSB first, with inc/skip/load/clear
// per word, overflow strobe and a parallel snapshot of each completed word.
module serial_count_line
  import edsac_ctrl_pkg::*;
#(
  parameter int unsigned WORD_LEN  = WORD_LEN_DEFAULT,
  parameter int unsigned OUT_DELAY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                word_start,
  input  logic                inc,
  input  logic                skip,
  input  logic                load,
  input  logic                load_data,
  input  logic                clear,
  output logic                cntr,
  output logic [WORD_LEN-1:0] count_par,
  output logic                count_valid,
  output logic                overflow
);

  localparam int unsigned PosW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [PosW-1:0] LastPos = PosW'(WORD_LEN - 1);

  logic [PosW-1:0]     bit_pos_q, bit_pos_d, pos;
  logic                at_first, at_second, at_last;
  cmd_e                cmd_q, cmd;
  logic                store_in, store_out;
  logic                addend, sum, carry_next;
  logic [WORD_LEN-1:0] shift_q, shift_d, count_par_q;
  logic [WORD_LEN:0]   shift_ext;
  logic                count_valid_q, overflow_q, overflow_d;

  // word_start resynchronises the word to position 0 in the same cycle.
  always_comb begin
    pos       = word_start ? '0 : bit_pos_q;
    at_first  = (pos == '0);
    at_second = (pos == PosW'(1));
    at_last   = (pos == LastPos);
    bit_pos_d = at_last ? '0 : pos + PosW'(1);
  end

  always_comb begin
    cmd    = at_first ? decode_cmd(inc, skip, load, clear) : cmd_q;
    addend = ((cmd == CMD_INC) && at_first) || ((cmd == CMD_SKIP) && at_second);
  end

  serial_full_adder u_adder (
    .clk_i       (clk),
    .reset_i     (reset),
    .carry_clr_i (at_first),
    .a_i         (store_out),
    .b_i         (addend),
    .sum_o       (sum),
    .carry_o     (carry_next)
  );

  always_comb begin
    store_in = sum;
    case (cmd)
      CMD_CLEAR: store_in = 1'b0;
      CMD_LOAD:  store_in = load_data;
      default:   store_in = sum;
    endcase
  end

  delay #(
    .INTERVAL (WORD_LEN)
  ) u_store (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (store_in),
    .q_o     (store_out)
  );

  delay #(
    .INTERVAL (OUT_DELAY)
  ) u_out_pipe (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (store_in),
    .q_o     (cntr)
  );

  // Bits enter at the MSB so the LSB lands at bit 0 once the word completes.
  always_comb begin
    shift_ext  = {store_in, shift_q};
    shift_d    = shift_ext[WORD_LEN:1];
    overflow_d = at_last && carry_next && ((cmd == CMD_INC) || (cmd == CMD_SKIP));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_pos_q     <= '0;
      cmd_q         <= CMD_IDLE;
      shift_q       <= '0;
      count_par_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      bit_pos_q     <= bit_pos_d;
      cmd_q         <= cmd;
      shift_q       <= shift_d;
      count_valid_q <= at_last;
      overflow_q    <= overflow_d;
      if (at_last) begin
        count_par_q <= shift_d;
      end
    end
  end

  assign count_par   = count_par_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_serial_count_line.sv
// Bench for serial_count_line: word-level arithmetic model scheduled onto a
// per-cycle expectation table, checked every cycle, plus directed literals.
module tb_serial_count_line;

  localparam int WL   = 18;
  localparam int OD   = 1;
  localparam int MAXC = 16384;

  logic          clk = 1'b0;
  logic          reset = 1'b0, word_start = 1'b0, inc = 1'b0, skip = 1'b0;
  logic          load = 1'b0, load_data = 1'b0, clear = 1'b0;
  logic          cntr, count_valid, overflow;
  logic [WL-1:0] count_par;

  always #5 clk = ~clk;

  serial_count_line #(
    .WORD_LEN  (WL),
    .OUT_DELAY (OD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .word_start  (word_start),
    .inc         (inc),
    .skip        (skip),
    .load        (load),
    .load_data   (load_data),
    .clear       (clear),
    .cntr        (cntr),
    .count_par   (count_par),
    .count_valid (count_valid),
    .overflow    (overflow)
  );

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  bit            checking = 1'b0;
  bit            e_cntr [MAXC];
  bit            e_valid[MAXC];
  bit            e_ovf  [MAXC];
  logic [WL-1:0] e_par  [MAXC];
  logic [WL-1:0] model_v = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Outputs are all registered; sample mid-cycle after the edge numbered cyc.
  always @(negedge clk) begin
    if (checking && cyc < MAXC) begin
      chk("cntr", 32'(cntr), 32'(e_cntr[cyc]));
      chk("count_valid", 32'(count_valid), 32'(e_valid[cyc]));
      chk("overflow", 32'(overflow), 32'(e_ovf[cyc]));
      chk("count_par", 32'(count_par), 32'(e_par[cyc]));
    end
  end

  task automatic step(input logic r, input logic ws, input logic i, input logic s,
                      input logic l, input logic ld, input logic c);
    reset = r; word_start = ws; inc = i; skip = s; load = l; load_data = ld; clear = c;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_from(input int r);
    for (int j = r; j < r + 2 * WL + OD + 1 && j < MAXC; j++) begin
      e_cntr[j] = 1'b0; e_valid[j] = 1'b0; e_ovf[j] = 1'b0; e_par[j] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      clear_from(cyc + 1);
      step(1'b1, 1'(($urandom_range(0, 1))), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checking = 1'b1;
    end
    model_v = '0;
  endtask

  // One word: compute its result arithmetically, schedule the expected
  // outputs, then drive it bit by bit (optionally cut short by a reset).
  task automatic run_word(input bit i, input bit s, input bit l, input bit c, input bit ws,
                          input logic [WL-1:0] ld_val, input bit noise, input int late_inc,
                          input int rst_at);
    int            t0;
    logic [WL:0]   total_sum;
    logic [WL-1:0] nv;
    bit            ov;
    logic          ni, ns, nl, nc, nd;
    t0 = cyc + 1;
    ov = 1'b0;
    total_sum = '0;
    if (c) nv = '0;
    else if (l) nv = ld_val;
    else if (s || i) begin
      total_sum = {1'b0, model_v} + (s ? (WL+1)'(2) : (WL+1)'(1));
      nv = total_sum[WL-1:0];
      ov = total_sum[WL];
    end else nv = model_v;
    for (int k = 0; k < WL; k++) begin
      e_cntr[t0 + k + OD - 1] = nv[k];
      e_par[t0 + WL - 1 + k]  = nv;
      e_valid[t0 + k]         = (k == WL - 1);
      e_ovf[t0 + k]           = (k == WL - 1) ? ov : 1'b0;
    end
    for (int k = 0; k < WL; k++) begin
      ni = noise ? 1'($urandom_range(0, 1)) : 1'(k == late_inc);
      ns = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      nl = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      nc = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      nd = (l && !c) ? ld_val[k] : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      if (k == rst_at) begin
        clear_from(cyc + 1);
        step(1'b1, 1'b0, ni, ns, nl, nd, nc);
        model_v = '0;
        return;
      end
      if (k == 0) step(1'b0, ws, i, s, l, nd, c);
      else step(1'b0, 1'b0, ni, ns, nl, nd, nc);
    end
    model_v = nv;
  endtask

  logic [WL-1:0] rv;
  int            sel, rat;

  initial begin
    do_reset(3);
    chk("reset_par", 32'(count_par), 32'd0);
    chk("reset_cntr", 32'(cntr), 32'd0);

    // Three inc words.
    repeat (3) run_word(1, 0, 0, 0, 1, '0, 0, -1, -1);
    chk("inc3_par", 32'(count_par), 32'd3);
    chk("inc3_valid", 32'(count_valid), 32'd1);
    chk("inc3_model", 32'(model_v), 32'd3);

    // Load 5 then skip.
    run_word(0, 0, 1, 0, 1, WL'(5), 0, -1, -1);
    chk("load5_par", 32'(count_par), 32'd5);
    run_word(0, 1, 0, 0, 1, '0, 0, -1, -1);
    chk("skip_par", 32'(count_par), 32'd7);
    chk("skip_ovf", 32'(overflow), 32'd0);

    // Load all-ones then inc wraps with overflow.
    run_word(0, 0, 1, 0, 1, {WL{1'b1}}, 0, -1, -1);
    run_word(1, 0, 0, 0, 1, '0, 0, -1, -1);
    chk("wrap_par", 32'(count_par), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_ovf_drop", 32'(overflow), 32'd0);
    run_word(0, 0, 0, 0, 0, '0, 0, -1, 0);

    // Clear beats inc; late inc is ignored.
    run_word(0, 0, 1, 0, 1, WL'(9), 0, -1, -1);
    chk("load9_par", 32'(count_par), 32'd9);
    run_word(1, 0, 0, 1, 1, '0, 0, -1, -1);
    chk("clr_inc_par", 32'(count_par), 32'd0);
    run_word(0, 0, 0, 0, 1, '0, 0, 5, -1);
    chk("late_inc_par", 32'(count_par), 32'd0);

    // Reset mid inc word.
    run_word(1, 0, 0, 0, 1, '0, 0, -1, -1);
    run_word(1, 0, 0, 0, 1, '0, 0, -1, 7);
    chk("midrst_par", 32'(count_par), 32'd0);
    chk("midrst_valid", 32'(count_valid), 32'd0);
    run_word(1, 0, 0, 0, 1, '0, 0, -1, -1);
    chk("midrst_inc_par", 32'(count_par), 32'd1);

    // Free-running without word_start.
    run_word(0, 0, 0, 1, 0, '0, 0, -1, -1);
    repeat (4) run_word(1, 0, 0, 0, 0, '0, 0, -1, -1);
    chk("free4_par", 32'(count_par), 32'd4);
    repeat (10) run_word(0, 0, 0, 0, 0, '0, 0, -1, -1);
    chk("idle10_par", 32'(count_par), 32'd4);
    chk("idle10_model", 32'(model_v), 32'd4);

    // Randomised words with noise off bit 0 and occasional mid-word resets.
    repeat (300) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) rv = {WL{1'b1}};
      else if (sel == 1) rv = {WL{1'b1}} - WL'(1);
      else rv = WL'($urandom);
      rat = ($urandom_range(0, 15) == 0) ? $urandom_range(1, WL - 1) : -1;
      run_word(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), rv, 1, -1, rat);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
